host_message_handler: RTL and testbench

HOST_MESSAGE_HANDLER -- requirements
Module: host_message_handler

---
 rtl/host_message_handler.sv | 198 +++++++++++++++++++
 tb/tb_host_message_handler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_message_handler.sv
// host_message_handler
//
// Byte-stream front end for a syndrome decoder core. The host opens a session with
// START_DECODING_MSG, then sends MEASUREMENT_DATA_HEADER followed by TOTAL_BYTES of
// byte-padded measurement data (each round padded up to a whole number of bytes).
// The pad bits are stripped into the dense `measurements` vector, the core is started,
// and when it finishes a response is streamed back: the iteration count, optionally
// followed by a 16-bit cycle count (MSB first). After a response the block waits for
// the next header; the session stays open.
//
// Build option:
//   HOST_CYCLE_COUNT_EN  defined   -> cycle counter built, 3-byte response
//                        undefined -> no cycle counter, 1-byte response
//
// Ports:
//   clk              single clock, all logic on posedge
//   reset            synchronous, active-high
//   input_data       host byte         (valid/ready handshake with input_valid/input_ready)
//   input_valid      input_data valid
//   input_ready      byte accepted when valid & ready
//   output_data      response byte     (valid/ready handshake with output_valid/output_ready)
//   output_valid     output_data valid
//   output_ready     host accepts response byte
//   measurements     unpadded syndrome vector to the decoder core
//   decoder_start    one-cycle start pulse to the core
//   decoder_done     one-cycle completion pulse from the core
//   iteration_count  core iteration count, valid with decoder_done
module host_message_handler #(
  parameter int unsigned GRID_WIDTH_X            = 6,
  parameter int unsigned GRID_WIDTH_Z            = 2,
  parameter int unsigned GRID_WIDTH_U            = 5,
  parameter logic [7:0]  START_DECODING_MSG      = 8'h01,
  parameter logic [7:0]  MEASUREMENT_DATA_HEADER = 8'h02,
  localparam int unsigned PPR         = GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int unsigned BPR         = (PPR + 7) / 8,
  localparam int unsigned TOTAL_BYTES = BPR * GRID_WIDTH_U,
  localparam int unsigned PU_COUNT    = PPR * GRID_WIDTH_U
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          input_data,
  input  logic                input_valid,
  output logic                input_ready,
  output logic [7:0]          output_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic [PU_COUNT-1:0] measurements,
  output logic                decoder_start,
  input  logic                decoder_done,
  input  logic [7:0]          iteration_count
);

  localparam int unsigned CntW = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
  localparam logic [CntW-1:0] LastByte = CntW'(TOTAL_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitHdr = 3'd1,
    StLoad    = 3'd2,
    StLaunch  = 3'd3,
    StRun     = 3'd4,
    StTxIter  = 3'd5
`ifdef HOST_CYCLE_COUNT_EN
    ,
    StTxCycHi = 3'd6,
    StTxCycLo = 3'd7
`endif
  } state_e;

  // Position of dense measurement bit m inside the padded byte stream.
  function automatic int unsigned pad_index(input int unsigned m);
    return (m / PPR) * BPR * 8 + (m % PPR);
  endfunction

  function automatic logic [CntW-1:0] pad_byte(input int unsigned m);
    return CntW'(pad_index(m) / 8);
  endfunction

  function automatic logic [2:0] pad_bit(input int unsigned m);
    return 3'(pad_index(m) % 8);
  endfunction

  state_e                state_q, state_d;
  logic [CntW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [PU_COUNT-1:0]   meas_q, meas_d;
  logic [7:0]            iter_q, iter_d;
`ifdef HOST_CYCLE_COUNT_EN
  logic [15:0]           cyc_q, cyc_d;
`endif

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    meas_d        = meas_q;
    iter_d        = iter_q;
`ifdef HOST_CYCLE_COUNT_EN
    cyc_d         = cyc_q;
`endif
    input_ready   = 1'b0;
    output_valid  = 1'b0;
    output_data   = 8'h00;
    decoder_start = 1'b0;

    // input_ready is a pure function of state, so the handshake terms below use the
    // raw valid/ready inputs inside the states where the partner side is ready.
    unique case (state_q)
      StIdle: begin
        input_ready = 1'b1;
        if (input_valid && input_data == START_DECODING_MSG) state_d = StWaitHdr;
      end
      StWaitHdr: begin
        input_ready = 1'b1;
        if (input_valid && input_data == MEASUREMENT_DATA_HEADER) begin
          state_d    = StLoad;
          byte_cnt_d = '0;
          meas_d     = '0;
        end
      end
      StLoad: begin
        input_ready = 1'b1;
        if (input_valid) begin
          // Scatter the current byte into every dense bit it feeds; pad bits have no
          // dense destination and fall away.
          for (int unsigned m = 0; m < PU_COUNT; m++) begin
            if (pad_byte(m) == byte_cnt_q) meas_d[m] = input_data[pad_bit(m)];
          end
          if (byte_cnt_q == LastByte) begin
            state_d = StLaunch;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      StLaunch: begin
        decoder_start = 1'b1;
`ifdef HOST_CYCLE_COUNT_EN
        cyc_d         = '0;
`endif
        state_d       = StRun;
      end
      StRun: begin
`ifdef HOST_CYCLE_COUNT_EN
        // Counts every RUN cycle including the one carrying decoder_done.
        if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
`endif
        if (decoder_done) begin
          iter_d  = iteration_count;
          state_d = StTxIter;
        end
      end
      StTxIter: begin
        output_valid = 1'b1;
        output_data  = iter_q;
`ifdef HOST_CYCLE_COUNT_EN
        if (output_ready) state_d = StTxCycHi;
`else
        if (output_ready) state_d = StWaitHdr;
`endif
      end
`ifdef HOST_CYCLE_COUNT_EN
      StTxCycHi: begin
        output_valid = 1'b1;
        output_data  = cyc_q[15:8];
        if (output_ready) state_d = StTxCycLo;
      end
      StTxCycLo: begin
        output_valid = 1'b1;
        output_data  = cyc_q[7:0];
        if (output_ready) state_d = StWaitHdr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      meas_q     <= '0;
      iter_q     <= '0;
`ifdef HOST_CYCLE_COUNT_EN
      cyc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      meas_q     <= meas_d;
      iter_q     <= iter_d;
`ifdef HOST_CYCLE_COUNT_EN
      cyc_q      <= cyc_d;
`endif
    end
  end

  assign measurements = meas_q;

endmodule

// File: tb/tb_host_message_handler.sv
module tb_host_message_handler;

`ifdef HOST_CYCLE_COUNT_EN
  localparam int NResp = 3;
`else
  localparam int NResp = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  input_data;
  logic        input_valid;
  logic        input_ready;
  logic [7:0]  output_data;
  logic        output_valid;
  logic        output_ready;
  logic [59:0] measurements;
  logic        decoder_start;
  logic        decoder_done;
  logic [7:0]  iteration_count;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int tx_cnt = 0;

  host_message_handler dut (
    .clk             (clk),
    .reset           (reset),
    .input_data      (input_data),
    .input_valid     (input_valid),
    .input_ready     (input_ready),
    .output_data     (output_data),
    .output_valid    (output_valid),
    .output_ready    (output_ready),
    .measurements    (measurements),
    .decoder_start   (decoder_start),
    .decoder_done    (decoder_done),
    .iteration_count (iteration_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      if (decoder_start) start_cnt <= start_cnt + 1;
      if (output_valid && output_ready) tx_cnt <= tx_cnt + 1;
    end
  end

  typedef struct {
    int          n;
    logic [7:0]  v;
    logic [59:0] meas;
    logic [7:0]  iter;
    int          dly;
    int          stall;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    input_data  = b;
    input_valid = 1'b1;
    while (!input_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!input_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
    @(posedge clk);
    #1;
    input_valid = 1'b0;
  endtask

  task automatic recv_byte(input int stall, output logic [7:0] b);
    int n = 0;
    logic [7:0] first;
    b = 8'h00;
    @(negedge clk);
    while (!output_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!output_valid) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout: no output_valid within 100 cycles");
      return;
    end
    first = output_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("tx_hold_data", output_data, first);
      check("tx_hold_valid", output_valid, 1'b1);
    end
    output_ready = 1'b1;
    b = output_data;
    @(posedge clk);
    #1;
    output_ready = 1'b0;
  endtask

  task automatic load_frame(input int n, input logic [7:0] v);
    send_byte(8'h01);
    send_byte(8'h02);
    for (int i = 0; i < 10; i++) send_byte(i == n ? v : 8'h00);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_session(input int n, input logic [7:0] v, input logic [59:0] exp_meas,
                             input logic [7:0] iter, input int dly, input int stall);
    int s0, t0;
    logic [15:0] cyc;
    logic [7:0] got;
    logic [7:0] exp_b [3];
    s0 = start_cnt;
    t0 = tx_cnt;
    cyc = 16'(dly);
    exp_b[0] = iter;
    exp_b[1] = cyc[15:8];
    exp_b[2] = cyc[7:0];
    load_frame(n, v);
    @(negedge clk);
    check("start_after_last_byte", decoder_start, 1'b1);
    check("meas_at_launch", measurements, exp_meas);
    for (int i = 0; i < dly; i++) @(posedge clk);
    #1;
    decoder_done    = 1'b1;
    iteration_count = iter;
    @(posedge clk);
    #1;
    decoder_done    = 1'b0;
    iteration_count = 8'hEE;
    for (int i = 0; i < NResp; i++) begin
      recv_byte(stall, got);
      check($sformatf("resp_byte%0d", i), got, exp_b[i]);
    end
    repeat (3) @(negedge clk);
    check("idle_after_resp_valid", output_valid, 1'b0);
    check("ready_after_resp", input_ready, 1'b1);
    check("meas_held", measurements, exp_meas);
    check("start_once", 64'(start_cnt - s0), 64'd1);
    check("resp_byte_count", 64'(tx_cnt - t0), 64'(NResp));
  endtask

  initial begin
    int s0, t0;
    reset           = 1'b1;
    input_data      = 8'h00;
    input_valid     = 1'b0;
    output_ready    = 1'b0;
    decoder_done    = 1'b0;
    iteration_count = 8'h00;

    vecs[0] = '{n: 0, v: 8'h01, meas: 60'h1,               iter: 8'h03, dly: 7,   stall: 0};
    vecs[1] = '{n: 1, v: 8'h10, meas: 60'h0,               iter: 8'h11, dly: 1,   stall: 1};
    vecs[2] = '{n: 2, v: 8'h01, meas: 60'h1000,            iter: 8'h22, dly: 2,   stall: 0};
    vecs[3] = '{n: 1, v: 8'h08, meas: 60'h800,             iter: 8'h33, dly: 3,   stall: 2};
    vecs[4] = '{n: 9, v: 8'h08, meas: 60'h800000000000000, iter: 8'h44, dly: 10,  stall: 0};
    vecs[5] = '{n: 0, v: 8'hFF, meas: 60'hFF,              iter: 8'h55, dly: 4,   stall: 3};
    vecs[6] = '{n: 1, v: 8'hFF, meas: 60'hF00,             iter: 8'h66, dly: 20,  stall: 0};
    vecs[7] = '{n: 5, v: 8'hA5, meas: 60'h500000000,       iter: 8'h77, dly: 5,   stall: 1};
    vecs[8] = '{n: 6, v: 8'h81, meas: 60'h81000000000,     iter: 8'hFE, dly: 300, stall: 0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_input_ready", input_ready, 1'b1);
    check("rst_output_valid", output_valid, 1'b0);
    check("rst_output_data", output_data, 8'h00);
    check("rst_decoder_start", decoder_start, 1'b0);
    check("rst_measurements", measurements, 60'h0);

    // Out-of-order bytes before and after the start message are discarded.
    s0 = start_cnt;
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h01);
    @(negedge clk);
    check("discard_meas", measurements, 60'h0);
    check("discard_no_start", 64'(start_cnt - s0), 64'd0);
    check("discard_ready", input_ready, 1'b1);
    run_session(0, 8'h01, 60'h1, 8'h03, 7, 0);

    for (int k = 0; k < 9; k++) begin
      run_session(vecs[k].n, vecs[k].v, vecs[k].meas, vecs[k].iter, vecs[k].dly, vecs[k].stall);
    end

    // Long host stall on every response byte.
    run_session(0, 8'h01, 60'h1, 8'h03, 7, 5);

    // decoder_done while waiting for a header must not produce a response.
    t0 = tx_cnt;
    @(negedge clk);
    decoder_done    = 1'b1;
    iteration_count = 8'h99;
    @(negedge clk);
    decoder_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_done_valid", output_valid, 1'b0);
    check("stray_done_tx", 64'(tx_cnt - t0), 64'd0);

    // Reset in the middle of a load.
    s0 = start_cnt;
    send_byte(8'h01);
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    @(negedge clk);
    check("midload_meas", measurements, 60'hFFFFFF);
    pulse_reset();
    check("midload_rst_meas", measurements, 60'h0);
    check("midload_rst_ready", input_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("midload_no_start", 64'(start_cnt - s0), 64'd0);
    run_session(2, 8'h01, 60'h1000, 8'h05, 6, 0);

    // Reset while the core runs: a late done must be ignored.
    load_frame(0, 8'h01);
    repeat (3) @(posedge clk);
    pulse_reset();
    s0 = start_cnt;
    t0 = tx_cnt;
    decoder_done = 1'b1;
    @(negedge clk);
    decoder_done = 1'b0;
    output_ready = 1'b1;
    repeat (5) @(negedge clk);
    output_ready = 1'b0;
    check("midrun_no_valid", output_valid, 1'b0);
    check("midrun_no_tx", 64'(tx_cnt - t0), 64'd0);
    check("midrun_no_start", 64'(start_cnt - s0), 64'd0);

    // Reset while a response byte is pending.
    load_frame(0, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    decoder_done    = 1'b1;
    iteration_count = 8'h42;
    @(posedge clk);
    #1;
    decoder_done = 1'b0;
    @(negedge clk);
    check("midtx_valid_before", output_valid, 1'b1);
    pulse_reset();
    t0 = tx_cnt;
    output_ready = 1'b1;
    repeat (5) @(negedge clk);
    output_ready = 1'b0;
    check("midtx_rst_valid", output_valid, 1'b0);
    check("midtx_rst_data", output_data, 8'h00);
    check("midtx_no_tx", 64'(tx_cnt - t0), 64'd0);

    run_session(9, 8'h08, 60'h800000000000000, 8'h07, 9, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
